// File: rtl/obstacle_scheduler.sv
// Obstacle lane scheduler: picks cactus or pterosaur, spacing, sprite,
// flight lane and scroll speed once per video frame; freezes on death.
module obstacle_scheduler #(
   parameter int unsigned MIN_GAP          = 40,
   parameter int unsigned GAP_RAND_BITS    = 6,
   parameter int unsigned PTERO_UNLOCK     = 8,
   parameter int unsigned SPEED_INIT       = 4,
   parameter int unsigned SPEED_MAX        = 12,
   parameter int unsigned SPEED_STEP_EVERY = 10,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic       frame_Clk,
   input  logic       Reset_n,
   input  logic [1:0] Game_State,
   input  logic       Dead,
   input  logic       Cactus_Done,
   input  logic       Ptero_Done,
   output logic       ca_off,
   output logic       pt_off,
   output logic [1:0] Cactus_Kind,
   output logic [1:0] Ptero_Lane,
   output logic [3:0] Scroll_Speed,
   output logic [7:0] Obstacle_Count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_PICK,
      S_ACTIVE,
      S_FROZEN
   } state_e;

   state_e      state_q;
   logic        ca_off_q;
   logic        pt_off_q;
   logic [1:0]  kind_q;
   logic [1:0]  lane_q;
   logic [3:0]  speed_q;
   logic [7:0]  count_q;
   logic [7:0]  step_q;
   logic [8:0]  gap_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   logic        go_idle;
   logic        freeze;
   logic        live;
   logic        pick_ptero;
   logic [1:0]  sel;
   logic [1:0]  lane_sel;
   logic [1:0]  kind_sel;
   logic [7:0]  count_inc;
   logic        step_wrap;
   logic [3:0]  speed_inc;
   logic        done_hit;
   logic [8:0]  gap_reload;

   // LFSR feedback: taps 16,14,13,11, shift left into bit 0
   always_comb begin
      lfsr_d = {lfsr_q[14:0],
                lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // Global control decode: return to idle, freeze, in-game states
   always_comb begin
      go_idle = (Game_State == 2'b00) || (Game_State == 2'b11);
      freeze  = Dead || (Game_State == 2'b10);
      live    = (state_q == S_GAP) || (state_q == S_PICK)
             || (state_q == S_ACTIVE);
   end

   // Spawn decision from the current random word
   always_comb begin
      sel        = lfsr_q[3:2];
      pick_ptero = (count_q >= 8'(PTERO_UNLOCK))
                && (lfsr_q[1:0] == 2'b11);
      lane_sel   = (sel == 2'd3) ? 2'd1 : sel;
      kind_sel   = (sel == 2'd3) ? 2'd0 : sel;
   end

   // Saturating spawn counter and speed ramp
   always_comb begin
      count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      step_wrap = (step_q + 8'd1 == 8'(SPEED_STEP_EVERY));
      speed_inc = (speed_q < 4'(SPEED_MAX)) ? speed_q + 4'd1 : speed_q;
   end

   // Despawn of the active type and the randomised gap that follows
   always_comb begin
      done_hit   = (!ca_off_q && Cactus_Done)
                || (!pt_off_q && Ptero_Done);
      gap_reload = 9'(MIN_GAP)
                 + 9'(lfsr_q[GAP_RAND_BITS-1:0]);
   end

   // Scheduler FSM with registered outputs; LFSR free-runs
   always_ff @(posedge frame_Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         ca_off_q <= 1'b1;
         pt_off_q <= 1'b1;
         kind_q   <= 2'd0;
         lane_q   <= 2'd0;
         speed_q  <= 4'(SPEED_INIT);
         count_q  <= 8'd0;
         step_q   <= 8'd0;
         gap_q    <= 9'd0;
         lfsr_q   <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
         if (go_idle) begin
            state_q  <= S_IDLE;
            ca_off_q <= 1'b1;
            pt_off_q <= 1'b1;
            speed_q  <= 4'(SPEED_INIT);
            count_q  <= 8'd0;
            step_q   <= 8'd0;
         end else if (live && freeze) begin
            state_q <= S_FROZEN;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (Game_State == 2'b01) begin
                     state_q <= S_GAP;
                     gap_q   <= 9'(MIN_GAP);
                  end
               end
               S_GAP: begin
                  if (gap_q == 9'd0) begin
                     state_q <= S_PICK;
                  end else begin
                     gap_q <= gap_q - 9'd1;
                  end
               end
               S_PICK: begin
                  if (pick_ptero) begin
                     pt_off_q <= 1'b0;
                     lane_q   <= lane_sel;
                  end else begin
                     ca_off_q <= 1'b0;
                     kind_q   <= kind_sel;
                  end
                  count_q <= count_inc;
                  if (step_wrap) begin
                     step_q  <= 8'd0;
                     speed_q <= speed_inc;
                  end else begin
                     step_q <= step_q + 8'd1;
                  end
                  state_q <= S_ACTIVE;
               end
               S_ACTIVE: begin
                  if (done_hit) begin
                     ca_off_q <= 1'b1;
                     pt_off_q <= 1'b1;
                     gap_q    <= gap_reload;
                     state_q  <= S_GAP;
                  end
               end
               S_FROZEN: begin
                  state_q <= S_FROZEN;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign ca_off         = ca_off_q;
   assign pt_off         = pt_off_q;
   assign Cactus_Kind    = kind_q;
   assign Ptero_Lane     = lane_q;
   assign Scroll_Speed   = speed_q;
   assign Obstacle_Count = count_q;

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Frame-rate scheduler that decides which obstacle, cactus or pterosaur, occupies the single obstacle lane, and when it appears. It drives the `ca_off`/`pt_off` enables consumed by the collision controller and by the obstacle draw/motion blocks. It also selects the sprite variant, pterosaur flight lane and scroll speed. Spacing between obstacles is randomised with an LFSR, and all scheduling freezes on death.

## Interface
- `MIN_GAP`, 40: minimum idle frames between obstacles. Range 1..255.
- `GAP_RAND_BITS`, 6: width of the LFSR slice added to the gap. Range 1..7.
- `PTERO_UNLOCK`, 8: spawns required before pterosaurs may be chosen.
- `SPEED_INIT`, 4: initial `Scroll_Speed` (px/frame).
- `SPEED_MAX`, 12: saturation value of `Scroll_Speed`. Must be ≤ 15.
- `SPEED_STEP_EVERY`, 10: `Scroll_Speed` increments by 1 after every this many spawns.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `frame_Clk` in 1: frame clock, one rising edge per video frame. One clock only.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Game_State` in 2: 00 Start, 01 Game, 10 Over. 11 is treated as 00.
- `Dead` in 1: collision flag, level.
- `Cactus_Done` in 1: one-cycle pulse when the cactus leaves the left screen edge.
- `Ptero_Done` in 1: one-cycle pulse when the pterosaur leaves the left screen edge.
- `ca_off` out 1: 1 = cactus inactive (not drawn, no collision).
- `pt_off` out 1: 1 = pterosaur inactive.
- `Cactus_Kind` out 2: cactus sprite variant, 0..2.
- `Ptero_Lane` out 2: pterosaur height, 0 high / 1 mid / 2 low.
- `Scroll_Speed` out 4: obstacle scroll speed.
- `Obstacle_Count` out 8: spawns this game, saturating at 255.

## Operation
- States: IDLE, GAP, PICK, ACTIVE, FROZEN. All outputs are registered.
- Priority each edge is: `Game_State`=00/11 → IDLE, then FROZEN entry, then normal transitions.
- **IDLE**
  - Holds `ca_off`=`pt_off`=1, `Scroll_Speed`=`SPEED_INIT`, `Obstacle_Count`=0, step counter=0.
  - `Game_State`=01 → GAP with `gap_cnt`=`MIN_GAP`.
- **GAP**
  - If `gap_cnt`==0 → PICK, otherwise `gap_cnt` decrements.
- **PICK** (exactly one cycle) uses the current LFSR value `r`.
  - Pterosaur is chosen if `Obstacle_Count` ≥ `PTERO_UNLOCK` and `r[1:0]`==11. Otherwise cactus.
  - `Ptero_Lane`/`Cactus_Kind` = `r[3:2]`, with 3 mapped to 1 for the lane and to 0 for the kind. Only the chosen type's select updates.
  - At the exiting edge the chosen `*_off` goes to 0 and `Obstacle_Count` increments (saturating).
  - The step counter increments. When it reaches `SPEED_STEP_EVERY` it clears and `Scroll_Speed` increments, saturating at `SPEED_MAX`.
  - Next state is ACTIVE.
- **ACTIVE**
  - Waits for the `Done` pulse of the active type only. The other type's `Done` is ignored.
  - On that pulse, the `*_off` goes to 1, `gap_cnt` = `MIN_GAP` + `r[GAP_RAND_BITS-1:0]`, and the state moves to GAP.
- **FROZEN**
  - Entered from GAP, PICK or ACTIVE when `Dead`=1 or `Game_State`=10.
  - Holds every output and counter, so a visible obstacle stays drawn.
  - Leaves only to IDLE, when `Game_State`=00/11.
- **LFSR**
  - 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
  - Advances every edge in all states, so time spent in IDLE seeds the randomness.

## Timing
- Reset values (asynchronous on `Reset_n`=0):
  - state IDLE, `ca_off`=1, `pt_off`=1, `Cactus_Kind`=0, `Ptero_Lane`=0.
  - `Scroll_Speed`=`SPEED_INIT`, `Obstacle_Count`=0, `gap_cnt`=0, LFSR=`LFSR_SEED`.
- Start latency: let E0 be the edge that samples `Game_State`=01 in IDLE. PICK occurs at E0+`MIN_GAP`+1, and `*_off` falls at E0+`MIN_GAP`+2.
- Despawn: `*_off` rises at the edge sampling `Done`. The next `*_off` fall comes gap+2 edges later, with gap in `MIN_GAP`..`MIN_GAP`+2^`GAP_RAND_BITS`-1.
- `Dead` and `Done` in the same cycle: `Dead` wins. The state goes to FROZEN and `*_off` stays 0.
- `Game_State`→00 from any state: IDLE outputs appear one edge later.
- `Reset_n` low mid-operation: reset values apply immediately, without waiting for an edge.
- At most one of `ca_off`/`pt_off` is 0 at any time.

## Test plan
- Reset, then `Game_State`=00 for 100 frames → all outputs hold their reset values, offs=1, `Scroll_Speed`=4.
- `Game_State`=01 at E0 → `ca_off`=0 exactly at E0+42, `pt_off`=1, `Obstacle_Count`=1, `Cactus_Kind` ≤ 2.
- With a cactus active: pulse `Ptero_Done` → no change. Pulse `Cactus_Done` → `ca_off`=1 next edge, and the next spawn comes 42..105 edges later.
- 200 spawns with immediate `Done` responses → `pt_off` never 0 during the first 8 spawns, both types occur afterwards, lane/kind never 3, and the two offs are never both 0.
- Spawn counting → `Scroll_Speed`=5 after spawn 10, 12 after spawn 80, still 12 after spawn 200. `Obstacle_Count` saturates at 255.
- `Dead`=1 in the same cycle as `Cactus_Done` → `ca_off` stays 0 and everything is frozen for 50 frames. Then `Game_State`=10 followed by 00 → one edge later offs=1, speed=4, count=0. Separately, `Reset_n`=0 mid-GAP → immediate reset values.
